// File: rtl/fifo_pkg.sv
// Shared definitions for the async_fifo write-side blocks: arbiter state type,
// default FIFO geometry and a width helper that never returns zero.
package fifo_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DSIZE = 8;
  localparam int DEFAULT_ASIZE = 4;

  // A one-entry index space still needs a one-bit field.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NREQ (NREQ need not be a power of two).
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = clog2_safe(NREQ)
) (
  input  logic [IW-1:0]   ptr,
  input  logic [NREQ-1:0] req_valid,
  output logic [IW-1:0]   idx,
  output logic            found
);

  localparam logic [IW:0] NREQ_W = NREQ[IW:0];

  logic [IW:0] cand_s;

  // Scan from the farthest offset down so the nearest valid index is written last.
  always_comb begin
    idx    = '0;
    cand_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s = {1'b0, ptr} + i[IW:0];
      cand_s = (cand_s >= NREQ_W) ? cand_s - NREQ_W : cand_s;
      idx    = req_valid[cand_s[IW-1:0]] ? cand_s[IW-1:0] : idx;
    end
    found = |req_valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked scheduler sharing the async_fifo write port among
// NREQ producers; wfull backpressure reaches only the current grant holder.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DSIZE = DEFAULT_DSIZE,
  parameter  int BURST = 4,
  localparam int IW    = clog2_safe(NREQ),
  localparam int CW    = clog2_safe(BURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic                  gnt_valid,
  output logic [IW-1:0]         gnt_id
);

  localparam int            NM1      = NREQ - 1;
  localparam int            BM1      = BURST - 1;
  localparam logic [IW-1:0] GNT_LAST = NM1[IW-1:0];
  localparam logic [CW-1:0] CNT_LAST = BM1[CW-1:0];

  arb_state_e    st_r;
  logic [IW-1:0] gnt_r;
  logic [IW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;

  logic [IW-1:0] gnt_inc_s;
  logic [IW-1:0] pick_ptr_s;
  logic [IW-1:0] pick_idx_s;
  logic          pick_found_s;
  logic          exit_s;

  // While locked the picker starts just past the holder, so a yield re-arbitrates in the same cycle.
  assign gnt_inc_s  = (gnt_r == GNT_LAST) ? '0 : gnt_r + 1'b1;
  assign pick_ptr_s = (st_r == LOCKED) ? gnt_inc_s : ptr_r;
  assign exit_s     = (winc && (cnt_r == CNT_LAST)) || !req_valid[gnt_r];

  rr_pick #(.NREQ(NREQ)) u_pick (
    .ptr       (pick_ptr_s),
    .req_valid (req_valid),
    .idx       (pick_idx_s),
    .found     (pick_found_s)
  );

  // Write-port mux: only the holder sees ready, and never while the FIFO is full.
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (st_r == LOCKED) begin
      req_ready[gnt_r] = ~wfull;
      winc             = req_valid[gnt_r] & ~wfull;
      wdata            = winc ? req_data[gnt_r*DSIZE +: DSIZE] : '0;
    end else begin
      req_ready = '0;
      winc      = 1'b0;
      wdata     = '0;
    end
  end

  assign gnt_valid = (st_r == LOCKED);
  assign gnt_id    = (st_r == LOCKED) ? gnt_r : '0;

  // Grant state machine: arbitration, burst counting and back-to-back hand-over.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      st_r  <= IDLE;
      gnt_r <= '0;
      ptr_r <= '0;
      cnt_r <= '0;
    end else begin
      case (st_r)
        IDLE: begin
          if (pick_found_s) begin
            st_r  <= LOCKED;
            gnt_r <= pick_idx_s;
            cnt_r <= '0;
          end else begin
            st_r <= IDLE;
          end
        end
        LOCKED: begin
          if (exit_s) begin
            ptr_r <= gnt_inc_s;
            cnt_r <= '0;
            if (pick_found_s) begin
              gnt_r <= pick_idx_s;
            end else begin
              st_r <= IDLE;
            end
          end else if (winc) begin
            cnt_r <= cnt_r + 1'b1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          st_r  <= IDLE;
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int IW    = 2;
  localparam int OW    = 1 + IW + 1 + DSIZE + NREQ;

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic                  gnt_valid;
  logic [IW-1:0]         gnt_id;

  int vectors     = 0;
  int miscompares = 0;

  logic [DSIZE-1:0] src_q [NREQ][$];
  logic [DSIZE-1:0] wr_log [$];

  // Model state: whether someone holds the port, who, where the next scan starts, beats done.
  bit m_locked;
  int m_holder;
  int m_start;
  int m_beats;

  logic [OW-1:0] act_vec;
  assign act_vec = {gnt_valid, gnt_id, winc, wdata, req_ready};

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 wclk = ~wclk;

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                 = (src_q[i].size() > 0);
      req_data[i*DSIZE +: DSIZE]   = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  function automatic int m_pick(input int s);
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(s + k) % NREQ]) return (s + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] m_expect();
    logic [NREQ-1:0]  rdy = '0;
    logic [DSIZE-1:0] d   = '0;
    logic             w   = 1'b0;
    logic [IW-1:0]    id  = '0;
    if (m_locked) begin
      id          = m_holder[IW-1:0];
      rdy[m_holder] = !wfull;
      w           = req_valid[m_holder] && !wfull;
      if (w) d = req_data[m_holder*DSIZE +: DSIZE];
    end
    return {m_locked, id, w, d, rdy};
  endfunction

  task automatic model_edge();
    int p;
    bit hs;
    if (!m_locked) begin
      p = m_pick(m_start);
      if (p >= 0) begin
        m_locked = 1'b1;
        m_holder = p;
        m_beats  = 0;
      end
    end else begin
      hs = req_valid[m_holder] && !wfull;
      if (hs) begin
        void'(src_q[m_holder].pop_front());
        m_beats++;
      end
      if (!req_valid[m_holder] || m_beats == BURST) begin
        m_start = (m_holder + 1) % NREQ;
        p = m_pick(m_start);
        if (p >= 0) begin
          m_holder = p;
          m_beats  = 0;
        end else begin
          m_locked = 1'b0;
        end
      end
    end
  endtask

  task automatic reset_model();
    m_locked = 1'b0;
    m_holder = 0;
    m_start  = 0;
    m_beats  = 0;
  endtask

  task automatic sample_fifo();
    if (winc === 1'b1) wr_log.push_back(wdata);
  endtask

  task automatic apply_reset();
    wrst  = 1'b1;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    wr_log.delete();
    drive_inputs();
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;
    reset_model();
  endtask

  task automatic test_reset();
    wrst  = 1'b1;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(8'h11 * i[7:0]);
    drive_inputs();
    repeat (2) begin
      @(negedge wclk);
      vectors++;
      if (act_vec !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %h, want %h", act_vec, {OW{1'b0}});
      end
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    for (int k = 0; k < 10; k++) src_q[0].push_back(8'hA0 + k[7:0]);
    for (int c = 0; c < 13; c++) begin
      drive_inputs();
      @(negedge wclk);
      sample_fifo();
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL single_cycle%0d: got %h, want %h", c, act_vec, m_expect());
      end
      model_edge();
      @(posedge wclk); #1;
    end
    vectors++;
    if (wr_log.size() !== 10) begin
      miscompares++;
      $display("FAIL single_count: got %0d beats, want 10", wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 10; k++) begin
      vectors++;
      if (wr_log[k] !== 8'hA0 + k[7:0]) begin
        miscompares++;
        $display("FAIL single_order%0d: got %h, want %h", k, wr_log[k], 8'hA0 + k[7:0]);
      end
    end
  endtask

  task automatic test_round_robin();
    int nhs = 0;
    apply_reset();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 2 * BURST; k++) src_q[i].push_back(8'($urandom));
    for (int c = 0; c < 1 + 2 * BURST * NREQ; c++) begin
      drive_inputs();
      @(negedge wclk);
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL rr_cycle%0d: got %h, want %h", c, act_vec, m_expect());
      end
      if (winc === 1'b1) begin
        vectors++;
        if (gnt_id !== 2'((nhs / BURST) % NREQ)) begin
          miscompares++;
          $display("FAIL rr_grant_beat%0d: got %0d, want %0d", nhs, gnt_id, (nhs / BURST) % NREQ);
        end
        nhs++;
      end
      model_edge();
      @(posedge wclk); #1;
    end
    vectors++;
    if (nhs !== 2 * BURST * NREQ) begin
      miscompares++;
      $display("FAIL rr_no_bubble: got %0d beats, want %0d", nhs, 2 * BURST * NREQ);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int k = 0; k < 4; k++) src_q[2].push_back(8'hC0 + k[7:0]);
    for (int c = 0; c < 12; c++) begin
      wfull = (c >= 2 && c < 7);
      drive_inputs();
      @(negedge wclk);
      sample_fifo();
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL bp_cycle%0d: got %h, want %h", c, act_vec, m_expect());
      end
      if (wfull) begin
        vectors++;
        if ({winc, req_ready, gnt_valid, gnt_id} !== {1'b0, 4'b0000, 1'b1, 2'd2}) begin
          miscompares++;
          $display("FAIL bp_hold%0d: got %b, want %b", c,
                   {winc, req_ready, gnt_valid, gnt_id}, {1'b0, 4'b0000, 1'b1, 2'd2});
        end
      end
      model_edge();
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
    vectors++;
    if (wr_log.size() !== 4) begin
      miscompares++;
      $display("FAIL bp_beats: got %0d, want 4", wr_log.size());
    end
  endtask

  task automatic test_early_yield();
    apply_reset();
    for (int k = 0; k < 2; k++) src_q[1].push_back(8'h10 + k[7:0]);
    for (int k = 0; k < 6; k++) src_q[3].push_back(8'h30 + k[7:0]);
    for (int c = 0; c < 12; c++) begin
      drive_inputs();
      @(negedge wclk);
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL yield_cycle%0d: got %h, want %h", c, act_vec, m_expect());
      end
      if (c == 4) begin
        vectors++;
        if ({gnt_id, winc, wdata} !== {2'd3, 1'b1, 8'h30}) begin
          miscompares++;
          $display("FAIL yield_switch: got %h, want %h", {gnt_id, winc, wdata}, {2'd3, 1'b1, 8'h30});
        end
      end
      model_edge();
      @(posedge wclk); #1;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'h50 + k[7:0]);
    for (int c = 0; c < 3; c++) begin
      drive_inputs();
      @(negedge wclk);
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL arst_pre%0d: got %h, want %h", c, act_vec, m_expect());
      end
      model_edge();
      @(posedge wclk); #1;
    end
    drive_inputs();
    #2;
    wrst = 1'b1;
    #1;
    vectors++;
    if (act_vec !== '0) begin
      miscompares++;
      $display("FAIL arst_immediate: got %h, want %h", act_vec, {OW{1'b0}});
    end
    @(posedge wclk); #1;
    wrst = 1'b0;
    reset_model();
    wr_log.delete();
    for (int c = 0; c < 10; c++) begin
      drive_inputs();
      @(negedge wclk);
      sample_fifo();
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL arst_post%0d: got %h, want %h", c, act_vec, m_expect());
      end
      model_edge();
      @(posedge wclk); #1;
    end
    vectors++;
    if (wr_log.size() == 0 || wr_log[0] !== 8'h52) begin
      miscompares++;
      $display("FAIL arst_resume: got %h, want 52", (wr_log.size() == 0) ? 8'hxx : wr_log[0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (src_q[i].size() < 3 && $urandom_range(0, 2) == 0) src_q[i].push_back(8'($urandom));
      wfull = ($urandom_range(0, 3) == 0);
      drive_inputs();
      @(negedge wclk);
      vectors++;
      if (act_vec !== m_expect()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h, want %h", c, act_vec, m_expect());
      end
      model_edge();
      @(posedge wclk); #1;
    end
    wfull = 1'b0;
  endtask

  initial begin
    wrst      = 1'b1;
    wfull     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    reset_model();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_early_yield();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
